// File: rtl/param_array_field_bank_pkg.sv
// Shared types and width helper for the parametrised field bank.
package param_array_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Index width for n items; a single-bit index is the floor so tiny arrays still get a port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_array_field_bank_if.sv
// Port bundle for the field bank: write port, read/compare port and scan control.
interface param_array_field_bank_if
    import param_array_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    parameter int FLD_W = 2
);
    localparam int ADDR_W = idx_width(DEPTH);
    localparam int LSB_W  = idx_width(WIDTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [LSB_W-1:0]  rd_lsb;
    logic [FLD_W-1:0]  cmp_val;
    logic [FLD_W-1:0]  rd_field;
    logic              rd_match;
    logic              rd_valid;
    logic              scan_start;
    logic [LSB_W-1:0]  scan_lsb;
    logic              scan_busy;
    logic              scan_done;
    logic              scan_hit;
    logic [ADDR_W-1:0] scan_idx;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_lsb, cmp_val,
               scan_start, scan_lsb,
        input  rd_field, rd_match, rd_valid, scan_busy, scan_done, scan_hit, scan_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_lsb, cmp_val,
               scan_start, scan_lsb,
        output rd_field, rd_match, rd_valid, scan_busy, scan_done, scan_hit, scan_idx
    );

endinterface

// File: rtl/param_array_field_bank_extract.sv
// Zero-filled bit-field extraction: bits past the top of the entry read as 0, no wrap.
module array_field_extract #(
    parameter int WIDTH = 3,
    parameter int FLD_W = 2,
    parameter int LSB_W = 2
) (
    input  logic [WIDTH-1:0] entry,
    input  logic [LSB_W-1:0] lsb,
    output logic [FLD_W-1:0] field
);

    // Logical right shift fills from the top with zeros, which gives the out-of-range behaviour.
    assign field = FLD_W'(entry >> lsb);

endmodule

// File: rtl/param_array_field_bank.sv
// Register-array bank with a registered field read/compare port and a first-match scan engine.
//
// state | meaning
// IDLE  | waiting for scan_start; key and lsb captured on start
// SCAN  | testing one entry per cycle, scan_busy high
// DONE  | one-cycle scan_done pulse, result on scan_hit/scan_idx
module param_array_field_bank
    import param_array_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    parameter int FLD_W = 2
) (
    input logic clk,
    input logic rst,
    param_array_field_bank_if.slave bus
);
    localparam int ADDR_W = idx_width(DEPTH);
    localparam int LSB_W  = idx_width(WIDTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_entry;
    logic [FLD_W-1:0]  rd_fld;
    logic [FLD_W-1:0]  scan_fld;

    scan_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [FLD_W-1:0]  key;
    logic [LSB_W-1:0]  lsb_cap;
    logic              busy_q;
    logic              done_q;
    logic              hit_q;
    logic [ADDR_W-1:0] hit_idx_q;
    logic [FLD_W-1:0]  rd_field_q;
    logic              rd_match_q;
    logic              rd_valid_q;

    // Read address beyond the populated entries returns an all-zero entry.
    always_comb begin
        rd_entry = '0;
        if (int'(bus.rd_addr) < DEPTH) rd_entry = mem[bus.rd_addr];
    end

    array_field_extract #(.WIDTH(WIDTH), .FLD_W(FLD_W), .LSB_W(LSB_W)) u_rd_extract (
        .entry (rd_entry),
        .lsb   (bus.rd_lsb),
        .field (rd_fld)
    );

    array_field_extract #(.WIDTH(WIDTH), .FLD_W(FLD_W), .LSB_W(LSB_W)) u_scan_extract (
        .entry (mem[idx]),
        .lsb   (lsb_cap),
        .field (scan_fld)
    );

    // Storage: cleared on reset, out-of-range write addresses dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read port: one-cycle latency, field and match hold when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_field_q <= '0;
            rd_match_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_field_q <= rd_fld;
                rd_match_q <= (rd_fld == bus.cmp_val);
            end
        end
    end

    // Scan engine: walks entries from index 0 and stops at the first field equal to the key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            key       <= '0;
            lsb_cap   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.scan_start) begin
                        key       <= bus.cmp_val;
                        lsb_cap   <= bus.scan_lsb;
                        idx       <= '0;
                        hit_q     <= 1'b0;
                        hit_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_fld == key) begin
                        hit_q     <= 1'b1;
                        hit_idx_q <= idx;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else if (idx == ADDR_W'(DEPTH - 1)) begin
                        hit_q     <= 1'b0;
                        hit_idx_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_field  = rd_field_q;
    assign bus.rd_match  = rd_match_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.scan_busy = busy_q;
    assign bus.scan_done = done_q;
    assign bus.scan_hit  = hit_q;
    assign bus.scan_idx  = hit_idx_q;

endmodule

// File: tb/tb_param_array_field_bank.sv
// Scoreboard bench for param_array_field_bank: driver pushes expectations, negedge monitor checks.
module tb_param_array_field_bank;
    import param_array_pkg::*;

    localparam int DEPTH  = 4;
    localparam int WIDTH  = 3;
    localparam int FLD_W  = 2;
    localparam int ADDR_W = idx_width(DEPTH);
    localparam int LSB_W  = idx_width(WIDTH);

    typedef struct {
        int field;
        int match;
    } rd_exp_t;

    typedef struct {
        int hit;
        int idx;
        int cyc;
    } scan_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    int   ref_mem [DEPTH];
    int   scan_end;
    rd_exp_t   rq[$];
    scan_exp_t sq[$];

    param_array_field_bank_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FLD_W(FLD_W)) bus ();

    param_array_field_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FLD_W(FLD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Field as defined: bits lsb.. of the entry, anything past the entry top is zero.
    function automatic int fld(input int v, input int lsb);
        return (v >> lsb) & ((1 << FLD_W) - 1);
    endfunction

    // One stimulus cycle; the model sees memory before this cycle's write (read-before-write).
    task automatic drive(input bit we, input int wa, input int wd,
                         input bit re, input int ra, input int rl, input int cv,
                         input bit ss, input int sl);
        bit we_eff;
        int f;
        @(negedge clk);
        #1;
        // Writes are kept out of scan windows so the scan model can use a memory snapshot.
        we_eff = we && !ss && (cyc > scan_end);
        bus.wr_en      = we_eff;
        bus.wr_addr    = ADDR_W'(wa);
        bus.wr_data    = WIDTH'(wd);
        bus.rd_en      = re;
        bus.rd_addr    = ADDR_W'(ra);
        bus.rd_lsb     = LSB_W'(rl);
        bus.cmp_val    = FLD_W'(cv);
        bus.scan_start = ss;
        bus.scan_lsb   = LSB_W'(sl);
        if (re) begin
            f = (ra < DEPTH) ? fld(ref_mem[ra], rl) : 0;
            rq.push_back('{f, int'(f == cv)});
        end
        if (ss && (cyc > scan_end)) begin
            scan_exp_t e;
            e = '{0, 0, cyc + DEPTH + 1};
            for (int j = 0; j < DEPTH; j++) begin
                if (fld(ref_mem[j], sl) == cv) begin
                    e = '{1, j, cyc + j + 2};
                    break;
                end
            end
            sq.push_back(e);
            scan_end = e.cyc;
        end
        if (we_eff && wa < DEPTH) ref_mem[wa] = wd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.scan_start = 1'b0;
        rq.delete();
        sq.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        scan_end = -1;
        @(negedge clk);
        #1;
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_rd_field", int'(bus.rd_field), 0);
        check("rst_rd_match", int'(bus.rd_match), 0);
        check("rst_scan_busy", int'(bus.scan_busy), 0);
        check("rst_scan_done", int'(bus.scan_done), 0);
        check("rst_scan_hit", int'(bus.scan_hit), 0);
        check("rst_scan_idx", int'(bus.scan_idx), 0);
        rst = 1'b0;
    endtask

    // Monitor: consumes expectations whenever the DUT presents a read result or a scan completion.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_valid) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected_valid", 1, 0);
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    check("rd_field", int'(bus.rd_field), e.field);
                    check("rd_match", int'(bus.rd_match), e.match);
                end
            end
            if (bus.scan_done) begin
                if (sq.size() == 0) begin
                    check("scan_unexpected_done", 1, 0);
                end else begin
                    scan_exp_t s;
                    s = sq.pop_front();
                    check("scan_hit", int'(bus.scan_hit), s.hit);
                    check("scan_idx", int'(bus.scan_idx), s.idx);
                    check("scan_done_cycle", cyc, s.cyc);
                    check("scan_busy_at_done", int'(bus.scan_busy), 0);
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        scan_end = -1;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_lsb = '0; bus.cmp_val = '0;
        bus.scan_start = 1'b0; bus.scan_lsb = '0;
        repeat (2) @(negedge clk);
        apply_reset();

        // Read of a cleared entry.
        drive(0, 0, 0, 1, 3, 0, 0, 0, 0);
        // Field select inside and straddling the entry top.
        drive(1, 2, 3'b110, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 1, 3, 0, 0);
        drive(0, 0, 0, 1, 2, 2, 3, 0, 0);
        // Same-edge read and write return the old data, then the new.
        drive(1, 1, 3'b111, 1, 1, 0, 3, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 3, 0, 0);

        // Scan with a hit at index 1.
        drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 3'b010, 0, 0, 0, 0, 0, 0);
        drive(1, 2, 3'b010, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 3'b001, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 2, 1, 0);
        idle();
        check("scan_busy_test0", int'(bus.scan_busy), 1);
        idle();
        check("scan_busy_test1", int'(bus.scan_busy), 1);
        idle();
        check("scan_busy_after_hit", int'(bus.scan_busy), 0);
        repeat (2) idle();

        // Full miss, with a second start during the scan that must be ignored.
        drive(0, 0, 0, 0, 0, 0, 3, 1, 0);
        idle();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (5) idle();

        // Reset during a scan clears outputs and memory.
        drive(0, 0, 0, 0, 0, 0, 3, 1, 0);
        idle();
        idle();
        check("scan_busy_before_rst", int'(bus.scan_busy), 1);
        apply_reset();
        for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, 1, a, 0, 0, 0, 0);
        repeat (2) idle();

        // Randomised traffic: writes, reads across all lsb values, concurrent scans.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 2) != 0), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, (1 << WIDTH) - 1),
                  ($urandom_range(0, 1) != 0), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, (1 << LSB_W) - 1), $urandom_range(0, (1 << FLD_W) - 1),
                  ($urandom_range(0, 5) == 0), $urandom_range(0, (1 << LSB_W) - 1));
        end

        for (int t = 0; t < 20 && (rq.size() != 0 || sq.size() != 0); t++) idle();
        repeat (2) idle();
        check("rd_queue_drained", rq.size(), 0);
        check("scan_queue_drained", sq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_array_field_bank.md
Name: param_array_field_bank

Overview:
Parametrised register-array bank holding DEPTH entries of WIDTH bits. It provides one write port, one registered read port with a variable bit-field select and compare, and a sequential scan engine that finds the first entry whose selected field equals a key. It generalises the fixed 2-D reg arrays with indexed part-select and compare used in our array parser test designs into a reusable, clocked storage block.

Parameters:
DEPTH, 4, number of entries (>=2); ADDR_W = $clog2(DEPTH) derived localparam
WIDTH, 3, bits per entry (>=2); LSB_W = $clog2(WIDTH) derived localparam
FLD_W, 2, extracted field width (1..WIDTH)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write entry index
wr_data  in  WIDTH  write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read entry index
rd_lsb  in  LSB_W  field start bit for read
cmp_val  in  FLD_W  compare key for read match and scan
rd_field  out  FLD_W  registered field of the read entry
rd_match  out  1  registered (rd_field == cmp_val)
rd_valid  out  1  high one cycle after an accepted rd_en
scan_start  in  1  start scan request
scan_lsb  in  LSB_W  field start bit for scan
scan_busy  out  1  scan in progress
scan_done  out  1  one-cycle completion pulse
scan_hit  out  1  match found (valid with scan_done, held until next start)
scan_idx  out  ADDR_W  first matching index (0 if no hit)

Behaviour:
- Reset: all entries 0. rd_field, rd_match, rd_valid, scan_busy, scan_done, scan_hit and scan_idx are all 0. FSM goes to IDLE. Captured scan key and lsb are cleared to 0.
- Field extract: field[i] = entry[lsb+i] when lsb+i < WIDTH, else 0. Out-of-range bits read as zero and never wrap.
- Write: on wr_en, mem[wr_addr] <= wr_data at the edge. wr_addr >= DEPTH (non-power-of-2 DEPTH) is ignored.
- Read: latency 1. On rd_en, the cycle-N inputs produce rd_field and rd_match in cycle N+1 with rd_valid=1.
- Without rd_en: rd_valid=0, and rd_field/rd_match hold their previous values. rd_addr >= DEPTH returns field 0.
- Same-cycle read and write to the same address: read-before-write, so the old data is returned.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE: on scan_start, capture cmp_val and scan_lsb, set idx=0, go to SCAN. scan_hit and scan_idx clear on entry to SCAN.
  - SCAN: scan_busy=1. Each cycle test mem[idx].
    - On a match: scan_hit<=1, scan_idx<=idx, go to DONE.
    - On a miss with idx==DEPTH-1: scan_hit<=0, scan_idx<=0, go to DONE.
    - Otherwise idx<=idx+1.
  - DONE: scan_done=1 and scan_busy=0 for exactly one cycle, then IDLE.
- Scan timing: worst case is DEPTH+1 cycles from start to done pulse. A hit at index k pulses done k+2 cycles after the start edge.
- scan_start while SCAN or DONE is ignored.
- A write during SCAN is allowed. The scan sees memory as of the cycle it tests each entry, with read-before-write applying.
- Read port and scan run concurrently and independently.
- rst asserted mid-scan: next edge returns to IDLE, all outputs 0, memory cleared.

Decomposition:
- Package param_array_pkg: scan state enum (IDLE, SCAN, DONE) and the ADDR_W/LSB_W derivation helper function.
- One natural sub-module: array_field_extract (combinational, parametrised WIDTH/FLD_W). It takes entry and lsb and outputs the zero-filled field. It is instantiated twice: once for the read path, once for the scan path.

Test Plan (defaults DEPTH=4, WIDTH=3, FLD_W=2):
- Reset then rd_en addr=3 lsb=0 -> next cycle rd_valid=1, rd_field=2'b00, rd_match=1 with cmp_val=0.
- Write mem[2]=3'b110; rd_en addr=2 lsb=1, cmp_val=3 -> rd_field=2'b11, rd_match=1. Then lsb=2 -> rd_field=2'b01 (bit3 out of range reads 0), rd_match=0.
- Same edge: wr_en addr=1 data=3'b111 and rd_en addr=1 lsb=0 -> rd_field=2'b00 (old data). Next read -> 2'b11.
- mem = {0:3'b000, 1:3'b010, 2:3'b010, 3:3'b001}; scan_start lsb=0 cmp_val=2 -> busy for 2 test cycles, done pulse 3 cycles after start, scan_hit=1, scan_idx=1.
- Same memory, cmp_val=3 -> done pulse 5 cycles after start, scan_hit=0, scan_idx=0. A second scan_start during busy is ignored.
- Assert rst two cycles into a scan -> next cycle scan_busy=0, scan_done=0, all memory reads return 0.
